// File: rtl/mag2_sqrt_feeder.sv
// mag2_sqrt_feeder
// Squared-magnitude front end for the iterative square-root unit. Each complex
// sample (re, im) is turned into re^2 + im^2 by a 3-stage pipeline, buffered in
// a FIFO, and handed to the square-root unit one value at a time using its
// din_valid/busy handshake.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   din_re/din_im  signed sample, DIN_POINT fractional bits
//   din_valid      qualifies din_re/din_im, any duty cycle
//   sqrt_busy      busy from the square-root unit
//   sqrt_din       squared magnitude, 2*DIN_POINT fractional bits, held until next issue
//   sqrt_din_valid one-cycle issue strobe
//   fifo_count     FIFO occupancy
//   overflow       sticky, set on the first dropped sample
//   drop_count     saturating count of dropped samples
module mag2_sqrt_feeder #(
  parameter int unsigned DIN_WIDTH  = 8,
  parameter int unsigned DIN_POINT  = 6,
  parameter int unsigned DOUT_WIDTH = 2 * DIN_WIDTH,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DIN_WIDTH-1:0]   din_re,
  input  logic signed [DIN_WIDTH-1:0]   din_im,
  input  logic                          din_valid,
  input  logic                          sqrt_busy,
  output logic [DOUT_WIDTH-1:0]         sqrt_din,
  output logic                          sqrt_din_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [DROP_WIDTH-1:0]         drop_count
);

  localparam int unsigned PW   = 2 * DIN_WIDTH;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  // Pipeline
  logic signed [DIN_WIDTH-1:0] re1_q, im1_q;
  logic                        v1_q, v2_q, v3_q;
  logic signed [PW-1:0]        re_ext, im_ext;
  logic signed [PW-1:0]        prr_d, pii_d, prr_q, pii_q;
  logic [DOUT_WIDTH-1:0]       sum_d, sum_q;

  // FIFO
  logic [DOUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, empty, wr_en, pop, drop;

  // Issue control
  state_e                state_q;
  logic                  wait_first_q;
  logic                  issue_ok;
  logic [DOUT_WIDTH-1:0] sqrt_din_q;
  logic                  sqrt_din_valid_q;
  logic                  overflow_q;
  logic [DROP_WIDTH-1:0] drop_count_q;

  always_comb begin
    re_ext = {{DIN_WIDTH{re1_q[DIN_WIDTH-1]}}, re1_q};
    im_ext = {{DIN_WIDTH{im1_q[DIN_WIDTH-1]}}, im1_q};
    prr_d  = re_ext * re_ext;
    pii_d  = im_ext * im_ext;
    // Both squares are non-negative and their sum tops out at 2^(PW-1), so the
    // unsigned sum fits without overflow.
    sum_d  = DOUT_WIDTH'($unsigned(prr_q)) + DOUT_WIDTH'($unsigned(pii_q));
  end

  always_comb begin
    full     = (count_q == CntW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    // The first WAIT cycle ignores busy: the root unit's busy is registered and
    // still reads low right after it captured the value.
    issue_ok = (state_q == StIdle) || ((state_q == StWait) && !wait_first_q);
    pop      = issue_ok && !empty && !sqrt_busy;
    // A pop in the same cycle frees a slot, so a write at full is still taken.
    wr_en    = v3_q && (!full || pop);
    drop     = v3_q && full && !pop;
    count_d  = count_q + CntW'(wr_en) - CntW'(pop);
  end

  // Storage has no reset; pointers and count define the contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= sum_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      re1_q            <= '0;
      im1_q            <= '0;
      v1_q             <= 1'b0;
      v2_q             <= 1'b0;
      v3_q             <= 1'b0;
      prr_q            <= '0;
      pii_q            <= '0;
      sum_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      overflow_q       <= 1'b0;
      drop_count_q     <= '0;
      state_q          <= StIdle;
      wait_first_q     <= 1'b0;
      sqrt_din_q       <= '0;
      sqrt_din_valid_q <= 1'b0;
    end else begin
      re1_q   <= din_re;
      im1_q   <= din_im;
      v1_q    <= din_valid;
      prr_q   <= prr_d;
      pii_q   <= pii_d;
      v2_q    <= v1_q;
      sum_q   <= sum_d;
      v3_q    <= v2_q;

      count_q <= count_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        sqrt_din_q <= mem_q[rd_ptr_q];
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != '1) begin
          drop_count_q <= drop_count_q + DROP_WIDTH'(1);
        end
      end

      sqrt_din_valid_q <= pop;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q <= StIssue;
          end
        end
        StIssue: begin
          state_q      <= StWait;
          wait_first_q <= 1'b1;
        end
        StWait: begin
          wait_first_q <= 1'b0;
          // Once busy is low again, go straight to the next issue if data waits.
          if (!wait_first_q && !sqrt_busy) begin
            state_q <= pop ? StIssue : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sqrt_din       = sqrt_din_q;
  assign sqrt_din_valid = sqrt_din_valid_q;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_mag2_sqrt_feeder.sv
// Self-checking bench for mag2_sqrt_feeder. A queue-based model predicts every
// output on every cycle; directed phases pin literal values from the test plan,
// followed by a randomized phase.
module tb_mag2_sqrt_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DROPW = 4;   // small so saturation is reachable
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] din_re = '0, din_im = '0;
  logic                 din_valid = 1'b0;
  logic                 sqrt_busy;
  logic [2*DW-1:0]      sqrt_din;
  logic                 sqrt_din_valid;
  logic [CW-1:0]        fifo_count;
  logic                 overflow;
  logic [DROPW-1:0]     drop_count;

  always #5 clk = ~clk;

  mag2_sqrt_feeder #(
    .DIN_WIDTH (DW),
    .DIN_POINT (6),
    .DOUT_WIDTH(2 * DW),
    .FIFO_DEPTH(DEPTH),
    .DROP_WIDTH(DROPW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din_re        (din_re),
    .din_im        (din_im),
    .din_valid     (din_valid),
    .sqrt_busy     (sqrt_busy),
    .sqrt_din      (sqrt_din),
    .sqrt_din_valid(sqrt_din_valid),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  // Square-root unit stand-in: busy rises one cycle after capture, stays 7 cycles.
  logic model_en  = 1'b1;
  logic hold_busy = 1'b0;
  logic start_q   = 1'b0;
  int   busy_left = 0;
  assign sqrt_busy = hold_busy | (busy_left != 0);

  always @(posedge clk) begin
    start_q <= model_en && sqrt_din_valid;
    if (start_q) busy_left <= 7;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] mag2(logic signed [7:0] r, logic signed [7:0] i);
    int a, b;
    a = r;
    b = i;
    return 16'(a * a + b * b);
  endfunction

  // Behavioural model state
  typedef struct { int t; logic [15:0] v; } pend_t;
  pend_t       pipeq[$];
  logic [15:0] fifoq[$];
  int          cyc = 0;
  int          last_issue = -100;
  logic [15:0] e_din = '0;
  logic        e_val = 1'b0;
  logic        e_ovf = 1'b0;
  int          e_drop = 0;

  // Observations gathered for directed checks
  logic [15:0] issued[$];
  int          issue_cyc[$];
  int          dv_cyc[$];
  int          peak = 0;
  int          busy_strobes = 0;

  initial begin
    logic s_rst, s_dv, s_busy, push, pop;
    logic signed [DW-1:0] s_re, s_im;
    logic [15:0] pv;
    forever begin
      @(posedge clk);
      cyc++;
      s_rst = rst; s_dv = din_valid; s_re = din_re; s_im = din_im; s_busy = sqrt_busy;
      if (s_rst) begin
        pipeq.delete();
        fifoq.delete();
        last_issue = -100;
        e_din = '0; e_val = 1'b0; e_ovf = 1'b0; e_drop = 0;
      end else begin
        pop  = (fifoq.size() > 0) && !s_busy && (cyc - last_issue >= 3);
        push = 1'b0;
        pv   = '0;
        if (pipeq.size() > 0 && pipeq[0].t == cyc) begin
          push = 1'b1;
          pv   = pipeq[0].v;
          void'(pipeq.pop_front());
        end
        e_val = pop;
        if (pop) begin
          e_din = fifoq.pop_front();
          last_issue = cyc;
        end
        if (push) begin
          if (fifoq.size() < DEPTH) fifoq.push_back(pv);
          else begin
            e_ovf = 1'b1;
            if (e_drop < (1 << DROPW) - 1) e_drop++;
          end
        end
        if (s_dv) begin
          pipeq.push_back('{t: cyc + 3, v: mag2(s_re, s_im)});
          dv_cyc.push_back(cyc);
        end
      end
      #1;
      chk("sqrt_din_valid", 32'(sqrt_din_valid), 32'(e_val));
      chk("sqrt_din", 32'(sqrt_din), 32'(e_din));
      chk("fifo_count", 32'(fifo_count), 32'(fifoq.size()));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("drop_count", 32'(drop_count), 32'(e_drop));
      if (sqrt_din_valid) begin
        issued.push_back(sqrt_din);
        issue_cyc.push_back(cyc);
        if (s_busy) busy_strobes++;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  end

  task automatic drive(input logic v, input logic [7:0] re, input logic [7:0] im);
    @(negedge clk);
    din_valid = v;
    din_re    = re;
    din_im    = im;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 8'h00);
  endtask

  task automatic clear_obs();
    issued.delete();
    issue_cyc.delete();
    dv_cyc.delete();
    peak = 0;
    busy_strobes = 0;
  endtask

  task automatic wait_issues(input int n, input int limit);
    int k;
    k = 0;
    while (issued.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("issue_total", 32'(issued.size()), 32'(n));
  endtask

  logic [15:0] sentq[$];

  initial begin
    logic [7:0] r, i;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single sample 1.0 + j1.0
    clear_obs();
    drive(1'b1, 8'h40, 8'h40);
    idle(1);
    wait_issues(1, 30);
    idle(12);
    if (issued.size() >= 1 && dv_cyc.size() >= 1) begin
      chk("single_value", 32'(issued[0]), 32'h2000);
      chk("single_latency", 32'(issue_cyc[0] - dv_cyc[0]), 32'd4);
    end
    chk("single_count_end", 32'(fifo_count), 32'd0);

    // Extremes, spaced out
    clear_obs();
    drive(1'b1, 8'h80, 8'h80); idle(14);
    drive(1'b1, 8'h7F, 8'h00); idle(14);
    drive(1'b1, 8'h00, 8'h00); idle(1);
    wait_issues(3, 40);
    idle(12);
    if (issued.size() >= 3) begin
      chk("ext_neg2", 32'(issued[0]), 32'h8000);
      chk("ext_7f", 32'(issued[1]), 32'h3F01);
      chk("ext_zero", 32'(issued[2]), 32'h0000);
    end

    // Burst of 10 with the 8-cycle root
    clear_obs();
    sentq.delete();
    for (int k = 0; k < 10; k++) begin
      r = 8'($urandom); i = 8'($urandom);
      sentq.push_back(mag2(r, i));
      drive(1'b1, r, i);
    end
    idle(1);
    wait_issues(10, 200);
    idle(12);
    for (int k = 0; k < 10 && k < issued.size(); k++) chk("burst_order", 32'(issued[k]), 32'(sentq[k]));
    chk("burst_peak", 32'(peak), 32'd9);
    chk("burst_busy_strobes", 32'(busy_strobes), 32'd0);
    chk("burst_overflow", 32'(overflow), 32'd0);

    // Burst of 20 with the root held busy
    clear_obs();
    sentq.delete();
    hold_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      r = 8'($urandom); i = 8'($urandom);
      sentq.push_back(mag2(r, i));
      drive(1'b1, r, i);
    end
    idle(6);
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_drops", 32'(drop_count), 32'd4);
    hold_busy = 1'b0;
    wait_issues(16, 400);
    idle(15);
    for (int k = 0; k < 16 && k < issued.size(); k++) chk("full_order", 32'(issued[k]), 32'(sentq[k]));
    chk("full_no_extra", 32'(issued.size()), 32'd16);

    // Root idle, continuous input: 3-cycle issue spacing, drops saturate
    model_en = 1'b0;
    idle(10);
    clear_obs();
    for (int k = 0; k < 80; k++) drive(1'b1, 8'($urandom), 8'($urandom));
    idle(60);
    for (int k = 1; k < issue_cyc.size(); k++)
      chk("spacing", 32'(issue_cyc[k] - issue_cyc[k-1]), 32'd3);
    chk("drop_saturated", 32'(drop_count), 32'hF);
    chk("drained", 32'(fifo_count), 32'd0);
    model_en = 1'b1;

    // Mid-operation reset: 5 buffered plus one in the pipeline
    hold_busy = 1'b1;
    for (int k = 0; k < 5; k++) drive(1'b1, 8'($urandom), 8'($urandom));
    idle(5);
    chk("pre_reset_count", 32'(fifo_count), 32'd5);
    drive(1'b1, 8'h11, 8'h22);
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_din", 32'(sqrt_din), 32'd0);
    chk("rst_valid", 32'(sqrt_din_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    hold_busy = 1'b0;
    clear_obs();
    idle(20);
    chk("rst_no_stale_issue", 32'(issued.size()), 32'd0);
    drive(1'b1, 8'hC0, 8'h40);
    idle(1);
    wait_issues(1, 30);
    if (issued.size() >= 1 && dv_cyc.size() >= 1) begin
      chk("post_rst_value", 32'(issued[0]), 32'h2000);
      chk("post_rst_latency", 32'(issue_cyc[0] - dv_cyc[0]), 32'd4);
    end
    idle(12);

    // Randomized traffic; the per-cycle model does the checking
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      din_valid = ($urandom_range(0, 99) < 45);
      din_re    = 8'($urandom);
      din_im    = 8'($urandom);
      if ($urandom_range(0, 99) < 3) hold_busy = ~hold_busy;
      if ($urandom_range(0, 199) == 0) model_en = ~model_en;
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    hold_busy = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
